pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameters REG_W, 4, register-index width (16 architectural registers).
REQ-002 The block SHALL have parameters RA_REG, 15, return-address register implicitly written by call and read by ret.
REQ-003 The block SHALL have parameters CNT_W, 16, width of the performance counters.
REQ-004 Ports, in order (name, direction, width, meaning):
- clk  in  1  the one clock; all state updates on posedge clk.
- rst  in  1  reset; synchronous, active-high.
- of_valid  in  1  OF stage holds a real instruction.
- of_rs1, of_rs2  in  REG_W  OF source register indices.
- of_use1, of_use2  in  1  OF instruction reads rs1 / rs2.
- of_isret  in  1  OF instruction reads RA_REG.
- of_rd  in  REG_W  OF destination index.
- of_iswb, of_isld, of_iscall  in  1  OF writes rd / is load / is call.
- ex_branch_taken  in  1  EX-stage branch/call/ret resolved taken this cycle.
- stall_if_of  out  1  hold PC and IF/OF register.
- bubble_ex  out  1  load NOP into OF/EX register.
- flush_if_of  out  1  load NOP into IF/OF register.
- fwd1_sel, fwd2_sel  out  2  operand source: 0 regfile, 1 EX result, 2 MA result, 3 RW result.
- state  out  2  FSM state encoding.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Function
REQ-005 The block SHALL keep a 3-entry shadow scoreboard (EX, MA, RW), each entry {valid, wr, isld, rd}, shifting EX->MA->RW every cycle; EX/MA/RW never stall.
REQ-006 Each cycle the EX entry SHALL load the OF fields when of_valid && !bubble_ex, else an invalid entry; rd SHALL be RA_REG and wr SHALL be 1 when of_iscall.
REQ-007 Operand sources SHALL be rs1 (if of_use1), rs2 (if of_use2), and RA_REG when of_isret (replaces rs2 for ret).
REQ-008 Load-use hazard SHALL be asserted when of_valid and the EX entry is valid && wr && isld and its rd matches any used source.
REQ-009 fwd*_sel SHALL be combinational: youngest matching valid writing entry wins (EX>MA>RW); no match or source unused -> 0.
REQ-010 FSM states SHALL be RUN(0), STALL(1), FLUSH(2).
REQ-011 In RUN, hazard && !ex_branch_taken SHALL assert stall_if_of=1 and bubble_ex=1 the same cycle, next state STALL.
REQ-012 In STALL the load has moved to MA; outputs SHALL be 0 (forwarding from MA resolves it), and the next state SHALL be RUN, or FLUSH on ex_branch_taken.
REQ-013 ex_branch_taken in any state SHALL assert flush_if_of=1 and bubble_ex=1 that cycle with stall_if_of=0, and the next state SHALL be FLUSH; flush SHALL override a coincident load-use stall.
REQ-014 FLUSH SHALL last exactly one cycle with all control outputs 0, then go to RUN; a new hazard there is evaluated as in RUN (RUN rules apply in FLUSH).
REQ-015 stall_cnt SHALL increment on every cycle with stall_if_of=1, flush_cnt on every cycle with flush_if_of=1; both SHALL saturate at all-ones.
REQ-016 A back-to-back load-use on consecutive instructions SHALL stall at most one cycle each.

Reset
REQ-017 While rst=1 at posedge clk: state=RUN, scoreboard entries invalid, both counters 0.
REQ-018 Combinational outputs during and after reset SHALL derive from the cleared state: stall_if_of, bubble_ex, flush_if_of, fwd*_sel all 0 with of_valid=0.
REQ-019 Reset asserted mid-STALL or mid-FLUSH SHALL abandon the sequence with no residual stall or flush.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding, the fwd_sel encodings, RA_REG, and the scoreboard-entry struct.
REQ-021 One sub-module SHALL be used: hazard_scoreboard (shift register plus match/priority logic); the FSM and counters SHALL live in the top.

Verification
REQ-022 ld r3 in OF, next add r4,r3,r5 -> one cycle stall_if_of=1 and bubble_ex=1, then fwd1_sel=2, stall_cnt=1.
REQ-023 add r2,... followed by sub r6,r2,r2 -> no stall, fwd1_sel=fwd2_sel=1; two instructions later, a reader of r2 sees 3.
REQ-024 Load-use hazard and ex_branch_taken in the same cycle -> flush_if_of=1, bubble_ex=1, stall_if_of=0, next state FLUSH, stall_cnt unchanged, flush_cnt+1.
REQ-025 call in EX followed by ret in OF -> fwd2_sel=1 (RA_REG match), no stall.
REQ-026 rst pulsed while in STALL -> next cycle state=RUN, outputs 0, counters 0; preload stall_cnt to 0xFFFF and force a stall -> stays 0xFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared encodings and scoreboard entry type for the hazard controller
package pipeline_hazard_ctrl_pkg;
  localparam int PKG_REG_W = 4;
  localparam logic [PKG_REG_W-1:0] RA_REG_IDX = 4'd15;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_STALL = 2'd1, ST_FLUSH = 2'd2} hz_state_t;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_EX = 2'd1;
  localparam logic [1:0] FWD_MA = 2'd2;
  localparam logic [1:0] FWD_RW = 2'd3;
  typedef struct packed {
    logic valid;
    logic wr;
    logic isld;
    logic [PKG_REG_W-1:0] rd;
  } sb_entry_t;
  function automatic logic hits(input sb_entry_t e, input logic [PKG_REG_W-1:0] src);
    return e.valid && e.wr && e.rd == src;
  endfunction
  function automatic logic [1:0] fwd_pick(input sb_entry_t ex, input sb_entry_t ma, input sb_entry_t rw,
                                          input logic use_src, input logic [PKG_REG_W-1:0] src);
    return !use_src ? FWD_RF : hits(ex, src) ? FWD_EX : hits(ma, src) ? FWD_MA : hits(rw, src) ? FWD_RW : FWD_RF;
  endfunction
endpackage

// File: rtl/pipeline_hazard_scoreboard.sv
// hazard_scoreboard: EX/MA/RW shadow of in-flight writers with load-use detection and forwarding priority
module hazard_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = PKG_REG_W,
  parameter logic [REG_W-1:0] RA_REG = RA_REG_IDX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             of_valid,
  input  logic [REG_W-1:0] of_rs1,
  input  logic [REG_W-1:0] of_rs2,
  input  logic             of_use1,
  input  logic             of_use2,
  input  logic             of_isret,
  input  logic [REG_W-1:0] of_rd,
  input  logic             of_iswb,
  input  logic             of_isld,
  input  logic             of_iscall,
  input  logic             bubble_ex,
  output logic             load_use,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel
);
  sb_entry_t ex_e, ma_e, rw_e, of_e;
  logic [REG_W-1:0] src2;
  logic use2;
  // a ret reads the return-address register in place of rs2
  always_comb begin
    src2 = of_isret ? RA_REG : of_rs2;
    use2 = of_isret | of_use2;
    of_e = '0;
    of_e.valid = of_valid && !bubble_ex;
    of_e.wr = of_e.valid && (of_iswb || of_iscall);
    of_e.isld = of_e.valid && of_isld;
    of_e.rd = of_iscall ? RA_REG : of_rd;
  end
  // EX/MA/RW never stall, so the shadow shifts every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_e <= '0;
      ma_e <= '0;
      rw_e <= '0;
    end else begin
      ex_e <= of_e;
      ma_e <= ex_e;
      rw_e <= ma_e;
    end
  end
  // a load in EX cannot forward yet; youngest writer wins otherwise
  always_comb begin
    load_use = of_valid && ex_e.valid && ex_e.wr && ex_e.isld &&
               ((of_use1 && ex_e.rd == of_rs1) || (use2 && ex_e.rd == src2));
    fwd1_sel = fwd_pick(ex_e, ma_e, rw_e, of_use1, of_rs1);
    fwd2_sel = fwd_pick(ex_e, ma_e, rw_e, use2, src2);
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall / branch flush sequencing with forwarding selects and event counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = PKG_REG_W,
  parameter logic [REG_W-1:0] RA_REG = RA_REG_IDX,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             of_valid,
  input  logic [REG_W-1:0] of_rs1,
  input  logic [REG_W-1:0] of_rs2,
  input  logic             of_use1,
  input  logic             of_use2,
  input  logic             of_isret,
  input  logic [REG_W-1:0] of_rd,
  input  logic             of_iswb,
  input  logic             of_isld,
  input  logic             of_iscall,
  input  logic             ex_branch_taken,
  output logic             stall_if_of,
  output logic             bubble_ex,
  output logic             flush_if_of,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  hz_state_t cur, nxt;
  logic load_use;
  hazard_scoreboard #(.REG_W(REG_W), .RA_REG(RA_REG)) u_sb (
    .clk(clk), .rst(rst), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
    .of_use1(of_use1), .of_use2(of_use2), .of_isret(of_isret), .of_rd(of_rd),
    .of_iswb(of_iswb), .of_isld(of_isld), .of_iscall(of_iscall), .bubble_ex(bubble_ex),
    .load_use(load_use), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) cur <= ST_RUN;
    else cur <= nxt;
  end
  // flush beats stall; in STALL the load sits in MA so no second stall is raised
  always_comb begin
    nxt = ST_RUN;
    stall_if_of = 1'b0;
    bubble_ex = 1'b0;
    flush_if_of = 1'b0;
    if (ex_branch_taken) begin
      flush_if_of = 1'b1;
      bubble_ex = 1'b1;
      nxt = ST_FLUSH;
    end else if (cur != ST_STALL && load_use) begin
      stall_if_of = 1'b1;
      bubble_ex = 1'b1;
      nxt = ST_STALL;
    end
  end
  assign state = cur;
  // saturating stall/flush event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(stall_if_of && !(&stall_cnt));
      flush_cnt <= flush_cnt + CNT_W'(flush_if_of && !(&flush_cnt));
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vector table, reset corner sequence and randomized model comparison
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic of_valid = 0, of_use1 = 0, of_use2 = 0, of_isret = 0, of_iswb = 0, of_isld = 0, of_iscall = 0, br = 0;
  logic [3:0] of_rs1 = 0, of_rs2 = 0, of_rd = 0;
  logic stall, bubble, flush, s_stall, s_bubble, s_flush;
  logic [1:0] f1, f2, st, s_f1, s_f2, s_st;
  logic [15:0] sc, fc;
  logic [2:0] s_sc, s_fc;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
    .of_use1(of_use1), .of_use2(of_use2), .of_isret(of_isret), .of_rd(of_rd),
    .of_iswb(of_iswb), .of_isld(of_isld), .of_iscall(of_iscall), .ex_branch_taken(br),
    .stall_if_of(stall), .bubble_ex(bubble), .flush_if_of(flush), .fwd1_sel(f1), .fwd2_sel(f2),
    .state(st), .stall_cnt(sc), .flush_cnt(fc)
  );
  pipeline_hazard_ctrl #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
    .of_use1(of_use1), .of_use2(of_use2), .of_isret(of_isret), .of_rd(of_rd),
    .of_iswb(of_iswb), .of_isld(of_isld), .of_iscall(of_iscall), .ex_branch_taken(br),
    .stall_if_of(s_stall), .bubble_ex(s_bubble), .flush_if_of(s_flush), .fwd1_sel(s_f1), .fwd2_sel(s_f2),
    .state(s_st), .stall_cnt(s_sc), .flush_cnt(s_fc)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input int rs1, input logic u1, input int rs2, input logic u2,
                       input logic ret, input int rd, input logic wb, input logic ld, input logic call, input logic b);
    of_valid = v; of_rs1 = 4'(rs1); of_use1 = u1; of_rs2 = 4'(rs2); of_use2 = u2; of_isret = ret;
    of_rd = 4'(rd); of_iswb = wb; of_isld = ld; of_iscall = call; br = b;
  endtask

  typedef struct {
    logic v; int rs1; logic u1; int rs2; logic u2; logic ret; int rd; logic wb, ld, call, b;
    int e_st; logic e_stall, e_bub, e_fl; int e_f1, e_f2, e_sc, e_fc;
  } vec_t;
  vec_t vt[16];

  function automatic vec_t mk(logic v, int rs1, logic u1, int rs2, logic u2, logic ret, int rd, logic wb,
                              logic ld, logic call, logic b, int e_st, logic e_stall, logic e_bub,
                              logic e_fl, int e_f1, int e_f2, int e_sc, int e_fc);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.ret = ret; r.rd = rd; r.wb = wb;
    r.ld = ld; r.call = call; r.b = b; r.e_st = e_st; r.e_stall = e_stall; r.e_bub = e_bub;
    r.e_fl = e_fl; r.e_f1 = e_f1; r.e_f2 = e_f2; r.e_sc = e_sc; r.e_fc = e_fc;
    return r;
  endfunction

  typedef struct {bit v, wr, ld; int rd;} ent_t;
  ent_t pipe[3];
  int m_last, m_sc, m_fc;

  function automatic int m_fwd(bit u, int src);
    if (!u) return 0;
    for (int i = 0; i < 3; i++)
      if (pipe[i].v && pipe[i].wr && pipe[i].rd == src) return i + 1;
    return 0;
  endfunction

  function automatic int pick_reg();
    int r = int'($urandom_range(0, 4));
    return r == 4 ? 15 : r;
  endfunction

  initial begin
    vt[0]  = mk(1,0,0,0,0,0,3,1,1,0,0,  0,0,0,0,0,0,0,0);
    vt[1]  = mk(1,3,1,5,1,0,4,1,0,0,0,  0,1,1,0,1,0,0,0);
    vt[2]  = mk(1,3,1,5,1,0,4,1,0,0,0,  1,0,0,0,2,0,1,0);
    vt[3]  = mk(1,4,1,4,1,0,6,1,0,0,0,  0,0,0,0,1,1,1,0);
    vt[4]  = mk(1,0,0,0,0,0,2,1,0,0,0,  0,0,0,0,0,0,1,0);
    vt[5]  = mk(1,2,1,2,1,0,6,1,0,0,0,  0,0,0,0,1,1,1,0);
    vt[6]  = mk(1,0,0,0,0,0,7,1,0,0,0,  0,0,0,0,0,0,1,0);
    vt[7]  = mk(1,2,1,0,0,0,0,0,0,0,0,  0,0,0,0,3,0,1,0);
    vt[8]  = mk(1,0,0,0,0,0,0,0,0,1,0,  0,0,0,0,0,0,1,0);
    vt[9]  = mk(1,0,0,0,0,1,0,0,0,0,0,  0,0,0,0,0,1,1,0);
    vt[10] = mk(1,0,0,0,0,0,8,1,1,0,0,  0,0,0,0,0,0,1,0);
    vt[11] = mk(1,8,1,0,0,0,9,1,0,0,1,  0,0,1,1,1,0,1,0);
    vt[12] = mk(0,0,0,0,0,0,0,0,0,0,0,  2,0,0,0,0,0,1,1);
    vt[13] = mk(1,0,0,0,0,0,9,1,1,0,0,  0,0,0,0,0,0,1,1);
    vt[14] = mk(1,9,1,0,0,0,10,1,0,0,0, 0,1,1,0,1,0,1,1);
    vt[15] = mk(1,9,1,0,0,0,10,1,0,0,0, 1,0,0,0,2,0,2,1);

    @(negedge clk);
    @(negedge clk);
    chk("rst_state", st, 0); chk("rst_stall", stall, 0); chk("rst_bubble", bubble, 0);
    chk("rst_flush", flush, 0); chk("rst_fwd1", f1, 0); chk("rst_fwd2", f2, 0);
    chk("rst_scnt", sc, 0); chk("rst_fcnt", fc, 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vt[i].v, vt[i].rs1, vt[i].u1, vt[i].rs2, vt[i].u2, vt[i].ret, vt[i].rd, vt[i].wb,
            vt[i].ld, vt[i].call, vt[i].b);
      #1;
      chk($sformatf("v%0d_state", i), st, vt[i].e_st);
      chk($sformatf("v%0d_stall", i), stall, vt[i].e_stall);
      chk($sformatf("v%0d_bubble", i), bubble, vt[i].e_bub);
      chk($sformatf("v%0d_flush", i), flush, vt[i].e_fl);
      chk($sformatf("v%0d_fwd1", i), f1, vt[i].e_f1);
      chk($sformatf("v%0d_fwd2", i), f2, vt[i].e_f2);
      chk($sformatf("v%0d_scnt", i), sc, vt[i].e_sc);
      chk($sformatf("v%0d_fcnt", i), fc, vt[i].e_fc);
    end

    @(negedge clk); drive(1,0,0,0,0,0,11,1,1,0,0);
    @(negedge clk); drive(1,11,1,0,0,0,12,1,0,0,0);
    #1 chk("seq_stall", stall, 1);
    @(negedge clk);
    chk("seq_in_stall", st, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; drive(0,0,0,0,0,0,0,0,0,0,0);
    #1;
    chk("seq_rst_state", st, 0); chk("seq_rst_stall", stall, 0); chk("seq_rst_flush", flush, 0);
    chk("seq_rst_bubble", bubble, 0); chk("seq_rst_fwd1", f1, 0);
    chk("seq_rst_scnt", sc, 0); chk("seq_rst_fcnt", fc, 0);

    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    m_last = 0; m_sc = 0; m_fc = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit r, v, u1, u2, ret, wb, ld, call, b, haz, e_stall, e_flush, u2e;
      int rs1, rs2, rd, s2;
      ent_t n;
      @(negedge clk);
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 7) != 0);
      rs1 = pick_reg(); rs2 = pick_reg(); rd = pick_reg();
      u1 = 1'($urandom); u2 = 1'($urandom); ret = ($urandom_range(0, 9) == 0);
      call = !ret && ($urandom_range(0, 9) == 0);
      ld = !call && ($urandom_range(0, 2) == 0);
      wb = 1'($urandom) | ld;
      b = ($urandom_range(0, 7) == 0);
      rst = r;
      drive(v, rs1, u1, rs2, u2, ret, rd, wb, ld, call, b);
      #1;
      s2 = ret ? 15 : rs2;
      u2e = ret | u2;
      haz = v && pipe[0].v && pipe[0].wr && pipe[0].ld &&
            ((u1 && pipe[0].rd == rs1) || (u2e && pipe[0].rd == s2));
      e_flush = b;
      e_stall = haz && !b && m_last != 1;
      chk("rnd_state", st, m_last);
      chk("rnd_stall", stall, e_stall);
      chk("rnd_bubble", bubble, e_stall | e_flush);
      chk("rnd_flush", flush, e_flush);
      chk("rnd_fwd1", f1, m_fwd(u1, rs1));
      chk("rnd_fwd2", f2, m_fwd(u2e, s2));
      chk("rnd_scnt", sc, m_sc);
      chk("rnd_fcnt", fc, m_fc);
      chk("rnd_sat_scnt", s_sc, m_sc > 7 ? 7 : m_sc);
      chk("rnd_sat_fcnt", s_fc, m_fc > 7 ? 7 : m_fc);
      if (r) begin
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
        m_last = 0; m_sc = 0; m_fc = 0;
      end else begin
        n.v = v && !(e_stall || e_flush);
        n.wr = n.v && (wb || call);
        n.ld = n.v && ld;
        n.rd = call ? 15 : rd;
        pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = n;
        m_sc = (m_sc + int'(e_stall) > 65535) ? 65535 : m_sc + int'(e_stall);
        m_fc = (m_fc + int'(e_flush) > 65535) ? 65535 : m_fc + int'(e_flush);
        m_last = e_flush ? 2 : e_stall ? 1 : 0;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
